// File: rtl/spi_frame_master.sv
// SPI mode-0 initiator: one parallel word per request, framed by cs_n with
// guaranteed lead, trail and deselect times; miso is captured in the same frame.
module spi_frame_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  cs_n,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_WIDTH);

    // Handshake contract: a word is accepted on a rising clk where
    // tx_valid & tx_ready; tx_ready is high only in IDLE, requests while busy are dropped.
    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t                state;
    logic [PW-1:0]         phase_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  phase_done;

    assign phase_done = (phase_cnt == PW'(CLK_DIV - 1));
    assign tx_ready   = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                    if (tx_valid) begin
                        tx_shift  <= tx_data;
                        mosi      <= tx_data[DATA_WIDTH-1];
                        cs_n      <= 1'b0;
                        phase_cnt <= '0;
                        state     <= LEAD;
                    end
                end
                LEAD: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // sclk itself tells which half of the bit period is running
                    if (phase_done) begin
                        phase_cnt <= '0;
                        if (!sclk) begin
                            sclk     <= 1'b1;
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                                state <= TRAIL;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                                mosi     <= tx_shift[DATA_WIDTH-2];
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        cs_n      <= 1'b1;
                        mosi      <= 1'b0;
                        rx_data   <= rx_shift;
                        rx_valid  <= 1'b1;
                        state     <= GAP;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
SPI mode-0 initiator (CPOL=0, CPHA=0) that serialises one parallel word per request onto cs_n/sclk/mosi and captures miso in the same frame. It sits on the FPGA side driving the SPI link toward the peripheral that frames on the chip-select edge. Each frame is bracketed by cs_n high→low and low→high transitions with guaranteed setup, trail and deselect times. The receiver can therefore detect every frame start from an idle-high line.

Parameters:
DATA_WIDTH, 8, bits per frame, MSB first, ≥2
CLK_DIV, 4, clk cycles per sclk half-period and per lead/trail/gap phase, ≥1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-low reset
tx_data  input  DATA_WIDTH  word to transmit, sampled on handshake
tx_valid  input  1  request to start a frame
tx_ready  output  1  high only in IDLE; handshake = tx_valid & tx_ready on a rising clk
busy  output  1  high in every state except IDLE
cs_n  output  1  chip select, active low, registered
sclk  output  1  serial clock, idle low, registered
mosi  output  1  serial data out, registered
miso  input  1  serial data in, synchronous to the sclk this block generates
rx_data  output  DATA_WIDTH  last received word, MSB first, holds until the next frame completes
rx_valid  output  1  one-cycle pulse when rx_data updates

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cs_n=1, sclk=0, mosi=0, rx_data=0, rx_valid=0. tx_ready=1 and busy=0 from the first cycle after release.
- States: IDLE → LEAD → SHIFT → TRAIL → GAP → IDLE. A phase counter counts CLK_DIV cycles. A bit counter counts 0..DATA_WIDTH-1.
- IDLE: cs_n=1, sclk=0.
  - On handshake, latch tx_data into the shift register and enter LEAD.
  - On the next cycle, cs_n=0 and mosi=tx_data[MSB].
- LEAD: CLK_DIV cycles, cs_n=0, sclk=0. Then enter SHIFT at bit 0.
- SHIFT: each bit takes 2*CLK_DIV cycles.
  - Low phase: CLK_DIV cycles, sclk=0, mosi stable.
  - High phase: CLK_DIV cycles, sclk=1.
  - miso is sampled into the receive shift register LSB on the same clk edge that drives sclk 0→1.
  - mosi advances to the next bit on the clk edge that drives sclk 1→0. It does not change during the high phase.
  - After the high phase of the last bit, sclk returns to 0 and the block enters TRAIL.
- TRAIL: CLK_DIV cycles, cs_n=0, sclk=0, mosi holds the last bit.
- On the TRAIL→GAP transition edge: cs_n←1, mosi←0, rx_data←receive shift register, rx_valid=1 for exactly that next cycle.
- GAP: CLK_DIV cycles with cs_n=1 (minimum deselect), then IDLE.
- Frame timing with defaults:
  - cs_n low for CLK_DIV*(2+2*DATA_WIDTH) = 72 cycles.
  - Handshake-to-handshake minimum is 72+CLK_DIV+1 = 77 cycles (cs_n high for ≥ CLK_DIV+1 cycles between frames).
  - sclk has exactly DATA_WIDTH rising edges per frame, high width = CLK_DIV cycles.
- tx_valid while busy: ignored, not queued. tx_data changes while busy have no effect.
- Back-to-back: if tx_valid is held, the next frame is accepted on the first IDLE cycle.
- Reset mid-frame: outputs return to reset values immediately, the frame is abandoned, and rx_valid is not asserted. The partially received word is discarded and rx_data is cleared to 0.
- No combinational path from any input to cs_n/sclk/mosi. tx_ready and busy decode directly from the state register.

Test Plan:
- Loopback (miso=mosi), CLK_DIV=4, DATA_WIDTH=8, tx_data=0xA5 → mosi bits 1,0,1,0,0,1,0,1 sampled at sclk rises; cs_n low exactly 72 cycles; 8 sclk rises each 4 cycles high; rx_data=0xA5 with one rx_valid pulse coincident with cs_n rising.
- miso tied 1, tx_data=0x00 → mosi 0 throughout the frame, rx_data=0xFF; miso tied 0, tx_data=0xFF → rx_data=0x00.
- tx_valid held, tx_data=0x3C then 0xC3 → two frames, cs_n high exactly 5 cycles between them, rx_data sequence 0x3C, 0xC3 (loopback), tx_ready high for 1 cycle between frames.
- Pulse tx_valid with 0x55 while busy (mid SHIFT) → no extra frame, tx_ready stays 0, current frame completes unaltered.
- Assert reset during bit 3 of SHIFT → same-cycle cs_n=1, sclk=0, mosi=0, rx_data=0, no rx_valid; after release, frame 0x81 completes correctly.
- CLK_DIV=1, DATA_WIDTH=16, loopback tx_data=0x1234 → sclk toggles every clk during SHIFT, cs_n low 34 cycles, rx_data=0x1234.
